// File: rtl/spi_master_ctrl.sv
// SPI master: turns host commands into 10-bit MOSI frames and captures an 8-bit MISO reply for read-data ops.
// Latency: START_CYC+10 cycles of SS_n low per frame, plus RD_GAP+8 more for read-data; rd_valid arrives in the first END cycle.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid outside IDLE is ignored and must be held by the host.
//
// Ports:
//   clk, rst           bit clock (one SPI bit per cycle), asynchronous active-high reset
//   cmd_valid/ready    command handshake; cmd_op = frame[9:8], cmd_data = frame[7:0]
//   SS_n, MOSI, MISO   serial interface, MSB first
//   rd_data, rd_valid  last captured read byte and its one-cycle update pulse
//   busy               high whenever the controller is not idle
module spi_master_ctrl #(
    parameter int START_CYC = 1,
    parameter int RD_GAP    = 2,
    parameter int IDLE_GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TX,
        S_GAP,
        S_RX,
        S_END
    } state_t;

    // Counters count down from (duration-1) and are reloaded on each state entry.
    localparam logic [3:0] START_LD = 4'(START_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(RD_GAP - 1);
    localparam logic [3:0] END_LD   = 4'(IDLE_GAP - 1);
    localparam logic [3:0] TX_LD    = 4'd9;
    localparam logic [3:0] RX_LD    = 4'd7;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [9:0] sh;
    logic [1:0] op;
    logic [7:0] cap;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = S_START;
                    cnt_nxt   = START_LD;
                end
            end
            S_START: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_TX;
                    cnt_nxt   = TX_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_TX: begin
                if (cnt == 4'd0) begin
                    if (op == 2'b11) begin
                        if (RD_GAP > 0) begin
                            state_nxt = S_GAP;
                            cnt_nxt   = GAP_LD;
                        end else begin
                            state_nxt = S_RX;
                            cnt_nxt   = RX_LD;
                        end
                    end else begin
                        state_nxt = S_END;
                        cnt_nxt   = END_LD;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RX;
                    cnt_nxt   = RX_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RX: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_END;
                    cnt_nxt   = END_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_END: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            sh       <= 10'd0;
            op       <= 2'b00;
            cap      <= 8'h00;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_valid <= 1'b0;

            // Outputs are registered from the next state so they line up with the state they belong to.
            SS_n <= (state_nxt == S_IDLE) || (state_nxt == S_END);
            MOSI <= (state_nxt == S_TX) ? sh[9] : 1'b0;

            if ((state == S_IDLE) && cmd_valid) begin
                sh <= {cmd_op, cmd_data};
                op <= cmd_op;
            end else if (state_nxt == S_TX) begin
                sh <= {sh[8:0], 1'b0};
            end

            // MISO is only looked at in RX, so an undriven line elsewhere never reaches state.
            if (state == S_RX) begin
                cap <= {cap[6:0], MISO};
                if (cnt == 4'd0) begin
                    rd_data  <= {cap[6:0], MISO};
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed and random frames checked cycle by cycle against a frame-level model.
// Latency: not applicable (testbench).
// Backpressure: host holds cmd_valid until accepted; a behavioural slave/RAM answers read-data frames on MISO.
module tb_spi_master_ctrl;

    localparam int START_CYC = 1;
    localparam int RD_GAP    = 2;
    localparam int IDLE_GAP  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Host-side model of the RAM, built from the commands issued.
    logic [7:0] model_ram [256];
    logic [7:0] model_addr;
    logic [7:0] rd_model;
    // Slave-side RAM, driven only by frames actually observed on MOSI.
    logic [7:0] slave_ram [256];
    logic [7:0] slave_addr;

    spi_master_ctrl #(
        .START_CYC(START_CYC),
        .RD_GAP   (RD_GAP),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic slave_apply(input logic [9:0] f);
        case (f[9:8])
            2'b00:   slave_addr = f[7:0];
            2'b01:   slave_ram[slave_addr] = f[7:0];
            2'b10:   slave_addr = f[7:0];
            default: ;
        endcase
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MISO = 1'bx;
            chk1("idle_ssn", SS_n, 1'b1);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_ready", cmd_ready, 1'b1);
            chk1("idle_rdv", rd_valid, 1'b0);
            chk8("idle_rdd", rd_data, rd_model);
        end
    endtask

    // Issue one command in the next (IDLE) cycle and check the whole frame.
    // abort_t >= 0 asserts reset at that frame cycle instead of finishing.
    task automatic do_frame(input logic [1:0] op, input logic [7:0] d, input bit keep,
                            input bit scramble, input int abort_t);
        int         len;
        int         total;
        int         rxs;
        logic [9:0] frame;
        logic [9:0] seen;
        logic [7:0] reply;
        logic       exp_ss;
        logic       exp_mosi;
        len   = START_CYC + 10 + ((op == 2'b11) ? (RD_GAP + 8) : 0);
        total = len + IDLE_GAP;
        rxs   = START_CYC + 10 + RD_GAP;
        frame = {op, d};
        seen  = '0;
        reply = '0;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        MISO      = 1'bx;
        chk1("acc_ready", cmd_ready, 1'b1);
        chk1("acc_ssn", SS_n, 1'b1);
        chk1("acc_busy", busy, 1'b0);
        @(posedge clk);

        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            if (scramble) begin
                cmd_op   = 2'($urandom);
                cmd_data = 8'($urandom);
            end
            if (t == abort_t) begin
                rst = 1'b1;
                #1;
                chk1("rst_ssn", SS_n, 1'b1);
                chk1("rst_mosi", MOSI, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_rdv", rd_valid, 1'b0);
                chk8("rst_rdd", rd_data, 8'h00);
                rd_model = 8'h00;
                @(negedge clk);
                rst       = 1'b0;
                cmd_valid = 1'b0;
                return;
            end
            if (op == 2'b11 && t == rxs)
                reply = (seen[9:8] == 2'b11) ? slave_ram[slave_addr] : 8'h00;
            if (op == 2'b11 && t >= rxs && t < rxs + 8)
                MISO = reply[7 - (t - rxs)];
            else
                MISO = 1'bx;

            exp_ss   = (t < len) ? 1'b0 : 1'b1;
            exp_mosi = (t >= START_CYC && t < START_CYC + 10) ? frame[9 - (t - START_CYC)] : 1'b0;
            chk1("frm_ssn", SS_n, exp_ss);
            chk1("frm_mosi", MOSI, exp_mosi);
            chk1("frm_busy", busy, 1'b1);
            chk1("frm_ready", cmd_ready, 1'b0);
            if (t >= START_CYC && t < START_CYC + 10)
                seen = {seen[8:0], MOSI};
            if (op == 2'b11 && t == len)
                rd_model = model_ram[model_addr];
            chk1("frm_rdv", rd_valid, (op == 2'b11 && t == len) ? 1'b1 : 1'b0);
            chk8("frm_rdd", rd_data, rd_model);
            if (t == len)
                slave_apply(seen);
        end

        case (op)
            2'b00:   model_addr = d;
            2'b01:   model_ram[model_addr] = d;
            2'b10:   model_addr = d;
            default: ;
        endcase
        if (!keep)
            cmd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rop;
        logic [7:0] rdat;
        bit         rkeep;
        bit         rscr;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = 8'h00;
        MISO       = 1'bx;
        model_addr = 8'h00;
        slave_addr = 8'h00;
        rd_model   = 8'h00;
        for (int i = 0; i < 256; i++) begin
            rdat         = 8'($urandom);
            model_ram[i] = rdat;
            slave_ram[i] = rdat;
        end

        repeat (2) @(negedge clk);
        chk1("reset_ssn", SS_n, 1'b1);
        chk1("reset_mosi", MOSI, 1'b0);
        chk8("reset_rdd", rd_data, 8'h00);
        chk1("reset_rdv", rd_valid, 1'b0);
        chk1("reset_ready", cmd_ready, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        rst = 1'b0;
        idle_cycles(2);

        // Write address 3C, write data A5.
        do_frame(2'b00, 8'h3C, 1'b0, 1'b0, -1);
        idle_cycles(2);
        do_frame(2'b01, 8'hA5, 1'b0, 1'b0, -1);
        idle_cycles(1);

        // Read data returning C3.
        model_ram[model_addr] = 8'hC3;
        slave_ram[slave_addr] = 8'hC3;
        do_frame(2'b11, 8'($urandom), 1'b0, 1'b0, -1);
        chk8("read_c3", rd_model, 8'hC3);
        idle_cycles(2);

        // Reset in the middle of a write-data frame.
        do_frame(2'b01, 8'hA5, 1'b0, 1'b0, 4);
        idle_cycles(3);

        // Back-to-back with cmd_valid held high.
        do_frame(2'b00, 8'h10, 1'b1, 1'b0, -1);
        do_frame(2'b01, 8'h5A, 1'b1, 1'b0, -1);
        do_frame(2'b10, 8'h10, 1'b1, 1'b0, -1);
        do_frame(2'b11, 8'($urandom), 1'b0, 1'b0, -1);
        chk8("b2b_final", rd_data, 8'h5A);
        idle_cycles(2);

        // Command inputs churn every cycle while busy.
        do_frame(2'b01, 8'h77, 1'b0, 1'b1, -1);
        idle_cycles(4);
        do_frame(2'b11, 8'h00, 1'b0, 1'b1, -1);
        idle_cycles(4);

        // Random command mix.
        for (int n = 0; n < 30; n++) begin
            rop   = 2'($urandom);
            rdat  = 8'($urandom);
            rkeep = (n == 29) ? 1'b0 : 1'($urandom_range(0, 1));
            rscr  = 1'($urandom_range(0, 1));
            do_frame(rop, rdat, rkeep, rscr, -1);
            if (!rkeep)
                idle_cycles($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
